// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM command monitor.
// Holds the command encodings {cs_n,ras_n,cas_n,we_n}, the monitor state
// encoding, the error-cause codes and the command decode helper.
package sdram_pkg;

   typedef enum logic [3:0] {
      CMD_MRS   = 4'b0000,
      CMD_AREF  = 4'b0001,
      CMD_PRE   = 4'b0010,
      CMD_ACT   = 4'b0011,
      CMD_WRITE = 4'b0100,
      CMD_READ  = 4'b0101,
      CMD_BST   = 4'b0110,
      CMD_NOP   = 4'b0111
   } cmd_e;

   typedef enum logic [2:0] {
      ST_POWER,
      ST_WAIT_PRE,
      ST_AREF,
      ST_READY,
      ST_ERR
   } state_e;

   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_EARLY      = 3'd1;
   localparam logic [2:0] ERR_SEQ        = 3'd2;
   localparam logic [2:0] ERR_TRP        = 3'd3;
   localparam logic [2:0] ERR_TRC        = 3'd4;
   localparam logic [2:0] ERR_TMRD       = 3'd5;
   localparam logic [2:0] ERR_AREF_SHORT = 3'd6;

   // A deselected device (cs_n high) sees the bus exactly like a NOP.
   function automatic cmd_e decode_cmd(input logic [3:0] raw);
      return raw[3] ? CMD_NOP : cmd_e'(raw);
   endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// sdram_gap_timer: counts NOP cycles since the last real command and flags
// tRP / tRC / tMRD gap violations against that command.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   i_hold             : freeze counter and last-command register
//   i_cmd              : decoded command sampled this cycle
//   o_trp_viol         : last command PRECHARGE and gap < TRP_CLK
//   o_trc_viol         : last command AUTO_REF and gap < TRC_CLK
//   o_tmrd_viol        : last command MRS and gap < TMRD_CLK
module sdram_gap_timer
   import sdram_pkg::*;
#(
   parameter int TRP_CLK  = 2,
   parameter int TRC_CLK  = 7,
   parameter int TMRD_CLK = 3
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic i_hold,
   input  cmd_e i_cmd,
   output logic o_trp_viol,
   output logic o_trc_viol,
   output logic o_tmrd_viol
);

   localparam logic [3:0] GAP_TRP  = 4'(TRP_CLK);
   localparam logic [3:0] GAP_TRC  = 4'(TRC_CLK);
   localparam logic [3:0] GAP_TMRD = 4'(TMRD_CLK);

   logic [3:0] r_gap_cnt;
   cmd_e       r_last_cmd;

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_gap_cnt  <= 4'd0;
         r_last_cmd <= CMD_NOP;
      end else if (!i_hold) begin
         r_gap_cnt  <= (i_cmd != CMD_NOP) ? 4'd0 : (r_gap_cnt == 4'hF) ? r_gap_cnt : r_gap_cnt + 4'd1;
         r_last_cmd <= (i_cmd != CMD_NOP) ? i_cmd : r_last_cmd;
      end

   assign o_trp_viol  = (r_last_cmd == CMD_PRE)  && (r_gap_cnt < GAP_TRP);
   assign o_trc_viol  = (r_last_cmd == CMD_AREF) && (r_gap_cnt < GAP_TRC);
   assign o_tmrd_viol = (r_last_cmd == CMD_MRS)  && (r_gap_cnt < GAP_TMRD);

endmodule

// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor: passive checker of the SDRAM power-up/init command
// sequence; captures the mode register and counts refreshes.
// Optional gap-timing checks (tRP/tRC/tMRD, codes 3..5) are built only when
// SDRAM_MON_TIMING_CHK_EN is defined.
// Ports:
//   sys_clk, sys_rst_n   : clock, asynchronous active-low reset
//   cmd_in/ba_in/addr_in : sampled {cs_n,ras_n,cas_n,we_n}, bank, A10..A0
//   init_done            : legal init completed (held while READY)
//   mode_valid/mode_reg  : captured MRS address; cas_lat/burst_len fields
//   aref_cnt / ref_cnt   : init refresh count / post-init refresh count
//   err_valid / err_code : sticky error flag and first error cause
module sdram_cmd_monitor
   import sdram_pkg::*;
#(
   parameter int T_POWER  = 20000,
   parameter int TRP_CLK  = 2,
   parameter int TRC_CLK  = 7,
   parameter int TMRD_CLK = 3,
   parameter int AREF_MIN = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  cmd_in,
   input  logic [1:0]  ba_in,
   input  logic [10:0] addr_in,
   output logic        init_done,
   output logic        mode_valid,
   output logic [10:0] mode_reg,
   output logic [2:0]  cas_lat,
   output logic [2:0]  burst_len,
   output logic [3:0]  aref_cnt,
   output logic [15:0] ref_cnt,
   output logic        err_valid,
   output logic [2:0]  err_code
);

   localparam int            PW         = $clog2(T_POWER + 1);
   localparam logic [PW-1:0] PWR_MAX    = PW'(T_POWER);
   localparam logic [3:0]    AREF_MIN_L = 4'(AREF_MIN);

   state_e        r_state, w_next;
   logic [PW-1:0] r_pwr_cnt;
   cmd_e          w_cmd;
   logic          w_nop, w_ba0, w_pwr_ok, w_pre_a10;
   logic          w_cap, w_aref_inc, w_ref_inc;
   logic          w_trp_viol, w_trc_viol, w_tmrd_viol;
   logic [2:0]    w_code;

   assign w_cmd     = decode_cmd(cmd_in);
   assign w_nop     = w_cmd == CMD_NOP;
   assign w_ba0     = ba_in == 2'b00;
   assign w_pwr_ok  = r_pwr_cnt == PWR_MAX;
   assign w_pre_a10 = (w_cmd == CMD_PRE) && addr_in[10];
   assign cas_lat   = mode_reg[6:4];
   assign burst_len = mode_reg[2:0];

`ifdef SDRAM_MON_TIMING_CHK_EN
   logic r_first;
   logic w_tmrd_raw;

   sdram_gap_timer #(
      .TRP_CLK  (TRP_CLK),
      .TRC_CLK  (TRC_CLK),
      .TMRD_CLK (TMRD_CLK)
   ) u_gap_timer (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .i_hold      (r_state == ST_ERR),
      .i_cmd       (w_cmd),
      .o_trp_viol  (w_trp_viol),
      .o_trc_viol  (w_trc_viol),
      .o_tmrd_viol (w_tmrd_raw)
   );

   // tMRD is only enforced on the first real command after the init MRS.
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) r_first <= 1'b0;
      else            r_first <= (w_next == ST_READY) && (r_state != ST_READY || (r_first && w_nop));

   assign w_tmrd_viol = r_first && w_tmrd_raw;
`else
   assign w_trp_viol  = 1'b0;
   assign w_trc_viol  = 1'b0;
   assign w_tmrd_viol = 1'b0;
`endif

   always_comb begin
      w_next     = r_state;
      w_code     = ERR_NONE;
      w_cap      = 1'b0;
      w_aref_inc = 1'b0;
      w_ref_inc  = 1'b0;
      case (r_state)
         // WAIT_PRE only differs from POWER in that pwr_cnt has saturated.
         ST_POWER, ST_WAIT_PRE: begin
            if (!w_nop && !w_pwr_ok) w_code = ERR_EARLY;
            else if (w_pre_a10)      w_next = ST_AREF;
            else if (!w_nop)         w_code = ERR_SEQ;
            else if (w_pwr_ok)       w_next = ST_WAIT_PRE;
         end
         // Priority chain yields the lowest code when causes coincide.
         ST_AREF: if (!w_nop) begin
            w_code     = !(w_cmd == CMD_AREF || (w_cmd == CMD_MRS && w_ba0)) ? ERR_SEQ :
                         w_trp_viol ? ERR_TRP :
                         w_trc_viol ? ERR_TRC :
                         (w_cmd == CMD_MRS && aref_cnt < AREF_MIN_L) ? ERR_AREF_SHORT : ERR_NONE;
            w_aref_inc = (w_code == ERR_NONE) && (w_cmd == CMD_AREF);
            w_cap      = (w_code == ERR_NONE) && (w_cmd == CMD_MRS);
            w_next     = w_cap ? ST_READY : r_state;
         end
         ST_READY: if (!w_nop) begin
            w_code    = w_tmrd_viol ? ERR_TMRD : ERR_NONE;
            w_ref_inc = !w_tmrd_viol && (w_cmd == CMD_AREF);
            w_cap     = !w_tmrd_viol && (w_cmd == CMD_MRS) && w_ba0;
         end
         default: ;
      endcase
      if (w_code != ERR_NONE) w_next = ST_ERR;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_state    <= ST_POWER;
         r_pwr_cnt  <= '0;
         init_done  <= 1'b0;
         mode_valid <= 1'b0;
         mode_reg   <= 11'd0;
         aref_cnt   <= 4'd0;
         ref_cnt    <= 16'd0;
         err_valid  <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         r_state    <= w_next;
         r_pwr_cnt  <= w_pwr_ok ? r_pwr_cnt : r_pwr_cnt + PW'(1);
         init_done  <= w_next == ST_READY;
         err_valid  <= w_next == ST_ERR;
         err_code   <= (w_code != ERR_NONE) ? w_code : err_code;
         mode_reg   <= w_cap ? addr_in : mode_reg;
         mode_valid <= mode_valid | w_cap;
         aref_cnt   <= (w_aref_inc && aref_cnt != 4'hF) ? aref_cnt + 4'd1 : aref_cnt;
         ref_cnt    <= (w_ref_inc && ref_cnt != 16'hFFFF) ? ref_cnt + 16'd1 : ref_cnt;
      end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// tb_sdram_cmd_monitor: scoreboard bench for sdram_cmd_monitor with directed
// init scenarios plus randomized init/traffic episodes against an event-history model.
module tb_sdram_cmd_monitor;

   localparam int TP   = 200;
   localparam int TRP  = 2;
   localparam int TRC  = 7;
   localparam int TMRD = 3;
   localparam int AMIN = 8;
`ifdef SDRAM_MON_TIMING_CHK_EN
   localparam bit TCHK = 1'b1;
`else
   localparam bit TCHK = 1'b0;
`endif

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] PRE  = 4'b0010;
   localparam logic [3:0] AREF = 4'b0001;
   localparam logic [3:0] MRS  = 4'b0000;
   localparam logic [3:0] ACT  = 4'b0011;
   localparam logic [3:0] RD   = 4'b0101;
   localparam logic [3:0] WR   = 4'b0100;
   localparam logic [3:0] BST  = 4'b0110;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [3:0]  cmd_in    = 4'b0111;
   logic [1:0]  ba_in     = 2'b00;
   logic [10:0] addr_in   = 11'd0;
   logic        init_done, mode_valid, err_valid;
   logic [10:0] mode_reg;
   logic [2:0]  cas_lat, burst_len, err_code;
   logic [3:0]  aref_cnt;
   logic [15:0] ref_cnt;

   sdram_cmd_monitor #(.T_POWER(TP)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cmd_in     (cmd_in),
      .ba_in      (ba_in),
      .addr_in    (addr_in),
      .init_done  (init_done),
      .mode_valid (mode_valid),
      .mode_reg   (mode_reg),
      .cas_lat    (cas_lat),
      .burst_len  (burst_len),
      .aref_cnt   (aref_cnt),
      .ref_cnt    (ref_cnt),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [7:0]  id;
      logic [42:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   tid    = 0;

   // Model: what has happened since reset, not how the RTL tracks it.
   int          n, m_err, m_arefs, m_refs, last_t;
   logic [3:0]  m_last;
   bit          m_pre, m_init, m_first, m_mv;
   logic [10:0] m_mode;

   function automatic logic [42:0] pk(bit ini, bit mv, logic [10:0] md, int ar, int rf, int ec);
      logic [3:0]  a4;
      logic [15:0] r16;
      logic [2:0]  e3;
      a4  = 4'(ar);
      r16 = 16'(rf);
      e3  = 3'(ec);
      return {ini, mv, md, md[6:4], md[2:0], a4, r16, ec != 0, e3};
   endfunction

   function automatic logic [3:0] rnop();
      logic [2:0] r;
      r = 3'($urandom);
      return ($urandom_range(0, 1) != 0) ? 4'b0111 : {1'b1, r};
   endfunction

   task automatic push_exp();
      exp_t e;
      e.id = 8'(tid);
      e.v  = pk(m_init && m_err == 0, m_mv, m_mode, m_arefs, m_refs, m_err);
      q.push_back(e);
   endtask

   task automatic m_reset();
      n = 0; m_err = 0; m_arefs = 0; m_refs = 0; last_t = 0;
      m_last = NOP; m_pre = 0; m_init = 0; m_first = 0; m_mv = 0; m_mode = 11'd0;
   endtask

   task automatic model(input logic [3:0] raw, input logic [1:0] ba, input logic [10:0] a);
      logic [3:0] c;
      int gap, code;
      c    = raw[3] ? NOP : raw;
      code = 0;
      if (m_err == 0 && c != NOP) begin
         gap = n - last_t - 1;
         if (gap > 15) gap = 15;
         if (!m_pre) begin
            if (n < TP) code = 1;
            else if (c != PRE || !a[10]) code = 2;
            else m_pre = 1;
         end else if (!m_init) begin
            if (!(c == AREF || (c == MRS && ba == 2'b00))) code = 2;
            else if (TCHK && m_last == PRE && gap < TRP) code = 3;
            else if (TCHK && m_last == AREF && gap < TRC) code = 4;
            else if (c == MRS && m_arefs < AMIN) code = 6;
            else if (c == AREF) begin
               if (m_arefs < 15) m_arefs++;
            end else begin
               m_mode = a; m_mv = 1; m_init = 1; m_first = 1;
            end
         end else begin
            if (TCHK && m_first && gap < TMRD) code = 5;
            else if (c == AREF) begin
               if (m_refs < 65535) m_refs++;
            end else if (c == MRS && ba == 2'b00) m_mode = a;
            m_first = 0;
         end
         m_last = c;
         last_t = n;
         m_err  = code;
      end
      n++;
   endtask

   task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [10:0] a);
      cmd_in  = c;
      ba_in   = b;
      addr_in = a;
      model(c, b, a);
      push_exp();
      @(negedge sys_clk);
   endtask

   task automatic nops(input int k);
      for (int i = 0; i < k; i++) step(rnop(), 2'($urandom), 11'($urandom));
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      cmd_in    = NOP;
      m_reset();
      push_exp();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic pre_a10();
      logic [9:0] lo;
      lo = 10'($urandom);
      step(PRE, 2'($urandom), {1'b1, lo});
   endtask

   task automatic arefs(input int cnt, input int gap);
      for (int i = 0; i < cnt; i++) begin
         step(AREF, 2'($urandom), 11'($urandom));
         nops(gap);
      end
   endtask

   task automatic traffic(input int k);
      logic [3:0] c;
      for (int i = 0; i < k; i++) begin
         case ($urandom_range(0, 7))
            0:       c = ACT;
            1:       c = RD;
            2:       c = WR;
            3:       c = BST;
            4:       c = PRE;
            5:       c = AREF;
            6:       c = MRS;
            default: c = rnop();
         endcase
         step(c, 2'($urandom), 11'($urandom));
         nops($urandom_range(0, 3));
      end
   endtask

   task automatic legal_init();
      nops(TP);
      pre_a10();
      nops(3);
      arefs(8, 8);
      step(MRS, 2'b00, 11'h037);
      nops(4);
   endtask

   // Monitor: compares the registered outputs just after each active edge.
   initial begin
      exp_t        e;
      logic [42:0] act;
      forever begin
         @(posedge sys_clk);
         #1;
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {init_done, mode_valid, mode_reg, cas_lat, burst_len, aref_cnt, ref_cnt, err_valid, err_code};
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL test%0d outputs {init,mv,mode,cas,bl,aref,ref,ev,ec}: got %h expected %h at n=%0d",
                        e.id, act, e.v, n);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end

   initial begin
      logic [1:0] b;
      logic [9:0] lo;
      logic       a10;
      int         k, na;
      m_reset();
      tid = 1;
      do_reset();
      legal_init();
      arefs(3, 8);
      step(MRS, 2'b00, 11'h027);
      nops(2);
      traffic(40);

      tid = 2;
      do_reset();
      nops(100);
      step(PRE, 2'b00, 11'h400);
      traffic(8);

      tid = 3;
      do_reset();
      nops(TP - 1);
      step(PRE, 2'b00, 11'h400);
      nops(3);

      tid = 4;
      do_reset();
      nops(TP);
      pre_a10();
      nops(3);
      step(AREF, 2'b00, 11'd0);
      nops(3);
      step(AREF, 2'b00, 11'd0);
      nops(3);

      tid = 5;
      do_reset();
      nops(TP);
      pre_a10();
      nops(TRP);
      arefs(7, TRC);
      step(MRS, 2'b00, 11'h037);
      nops(3);

      tid = 6;
      do_reset();
      nops(TP + 5);
      step(PRE, 2'b00, 11'h3FF);
      nops(3);

      tid = 7;
      do_reset();
      nops(TP);
      pre_a10();
      nops(3);
      arefs(4, 8);
      do_reset();
      legal_init();
      traffic(10);

      for (int ep = 0; ep < 12; ep++) begin
         tid = 20 + ep;
         do_reset();
         k = ($urandom_range(0, 15) == 0) ? $urandom_range(0, TP - 1) : TP;
         nops(k);
         a10 = $urandom_range(0, 7) != 0;
         lo  = 10'($urandom);
         step(PRE, 2'($urandom), {a10, lo});
         nops($urandom_range(0, 4));
         na = $urandom_range(6, 10);
         for (int i = 0; i < na; i++) begin
            step(($urandom_range(0, 19) == 0) ? ACT : AREF, 2'($urandom), 11'($urandom));
            nops($urandom_range(5, 9));
         end
         b = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         step(MRS, b, 11'($urandom));
         nops($urandom_range(0, 4));
         traffic(20);
      end

      @(negedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_monitor.md
SDRAM_CMD_MONITOR -- requirements
Module: sdram_cmd_monitor

Interface
REQ-001 Parameter T_POWER, default 20000: power-up stabilisation cycles before the first legal command.
REQ-002 Parameter TRP_CLK, default 2: minimum NOP cycles after PRECHARGE.
REQ-003 Parameter TRC_CLK, default 7: minimum NOP cycles after AUTO_REF.
REQ-004 Parameter TMRD_CLK, default 3: minimum NOP cycles after MRS.
REQ-005 Parameter AREF_MIN, default 8: minimum AUTO_REF count before MRS during init.
REQ-006 sys_clk  input  1  clock, 100 MHz.
REQ-007 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 cmd_in  input  4  sampled SDRAM command {cs_n,ras_n,cas_n,we_n}.
REQ-009 ba_in  input  2  sampled bank address.
REQ-010 addr_in  input  11  sampled address A10..A0.
REQ-011 init_done  output  1  legal init sequence completed.
REQ-012 mode_valid  output  1  mode_reg holds a captured MRS value.
REQ-013 mode_reg  output  11  last legal MRS address; cas_lat output 3 = mode_reg[6:4]; burst_len output 3 = mode_reg[2:0].
REQ-014 aref_cnt  output  4  init AUTO_REF count, saturating at 15.
REQ-015 ref_cnt  output  16  AUTO_REF count after init_done, saturating at 16'hFFFF.
REQ-016 err_valid  output  1  sticky error flag; err_code  output  3  first error cause.

Function
REQ-017 Commands SHALL decode as: NOP 0111, PRECHARGE 0010, AUTO_REF 0001, MRS 0000, ACTIVE 0011, READ 0101, WRITE 0100, BURST_STOP 0110; cs_n=1 SHALL be treated as NOP.
REQ-018 All outputs SHALL be registered and update the cycle after the command is sampled.
REQ-019 pwr_cnt SHALL increment from 0 after reset, saturating at T_POWER.
REQ-020 gap_cnt SHALL clear on any non-NOP command and increment (saturating at 15) on each NOP.
REQ-021 States: POWER, WAIT_PRE, AREF, READY, ERR.
REQ-022 POWER: NOP stays; non-NOP with pwr_cnt<T_POWER -> ERR code 1 (EARLY); PRECHARGE with A10=1 at pwr_cnt==T_POWER -> AREF.
REQ-023 WAIT_PRE is entered from POWER when pwr_cnt reaches T_POWER; PRECHARGE with A10=1 -> AREF; any other non-NOP -> ERR code 2 (SEQ).
REQ-024 AREF: AUTO_REF increments aref_cnt; MRS with ba_in==00 and aref_cnt>=AREF_MIN captures mode_reg, sets mode_valid -> READY; MRS with aref_cnt<AREF_MIN -> ERR code 6 (AREF_SHORT); MRS with ba_in!=00 or any other command -> ERR code 2.
REQ-025 READY: init_done=1 asserted the cycle after the MRS is sampled and held while in READY; AUTO_REF increments ref_cnt; MRS with ba_in==00 recaptures mode_reg; ACTIVE/READ/WRITE/BURST_STOP/PRECHARGE legal, no checks.
REQ-026 Timing: in AREF, a non-NOP command with previous command PRECHARGE and gap_cnt<TRP_CLK -> code 3; previous AUTO_REF and gap_cnt<TRC_CLK -> code 4; in READY, first non-NOP after init MRS with gap_cnt<TMRD_CLK -> code 5.
REQ-027 Simultaneous causes: lowest err_code wins.
REQ-028 ERR: err_valid=1, err_code frozen, init_done=0; exit only by reset; mode_reg and counters hold.

Reset
REQ-029 On reset: state POWER, pwr_cnt=0, gap_cnt=0, init_done=0, mode_valid=0, mode_reg=0, aref_cnt=0, ref_cnt=0, err_valid=0, err_code=0.
REQ-030 Reset asserted mid-sequence SHALL abort immediately; monitoring restarts from POWER on release.

Configuration
REQ-031 Macro SDRAM_MON_TIMING_CHK_EN: defined -> REQ-026 checks active; undefined -> gap_cnt and codes 3/4/5 removed, err_code never 3..5, sequence checks unchanged.

Structure
REQ-032 Shared package sdram_pkg SHALL hold command encodings, state encoding, and error codes.
REQ-033 One sub-module sdram_gap_timer SHALL hold gap_cnt, last-command register, and threshold compares.

Verification
REQ-034 Legal init (defaults, 3 NOP after PRE, 8x AREF with 8 NOP gaps, MRS addr 11'h037, 4 NOP) -> init_done=1, mode_reg=11'h037, cas_lat=3, burst_len=7, aref_cnt=8, err_valid=0.
REQ-035 PRECHARGE at pwr_cnt=100 -> err_valid=1, err_code=1, init_done stays 0.
REQ-036 AUTO_REF 4 cycles after previous AUTO_REF (TRC_CLK=7) -> err_code=4; repeat with macro undefined -> no error.
REQ-037 MRS after 7 AUTO_REF -> err_code=6; PRECHARGE with A10=0 in WAIT_PRE -> err_code=2.
REQ-038 After init_done, 3x AUTO_REF then MRS addr 11'h027 -> ref_cnt=3, cas_lat=2; reset asserted mid-AREF -> all outputs zero, restart in POWER.
